binary_add_arbiter: RTL and testbench
=====================================

// Module: binary_add_arbiter
// PURPOSE
//  Shares one registered 9-bit adder (1-cycle latency, clock-enabled) between N_REQ requesters.
//  - Round-robin arbitration with a valid/ready request handshake per requester.
//  - Sequences the adder's enable: operands are held for one cycle, then the sum is captured.
//  - Returns each sum to the requester that was granted, over a per-requester valid/ready response.
//  - Sits between the requesting blocks and a single binary adder instance.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  WIDTH   9   operand/sum width; must match the adder instance
// PORTS
//  clk         in   1              system clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  req_valid   in   N_REQ          requester i has operands pending
//  req_ready   out  N_REQ          one-hot grant; accept = req_valid[i] & req_ready[i]
//  req_a       in   N_REQ*WIDTH    operand A, slice i = [i*WIDTH +: WIDTH]
//  req_b       in   N_REQ*WIDTH    operand B, same packing as req_a
//  rsp_valid   out  N_REQ          one-hot; sum ready for requester i
//  rsp_ready   in   N_REQ          requester i takes its sum
//  rsp_s       out  WIDTH          sum for the requester flagged in rsp_valid
//  add_en      out  1              to the adder's en input
//  add_a       out  WIDTH          to the adder's A input
//  add_b       out  WIDTH          to the adder's B input
//  add_s       in   WIDTH          from the adder's S output (registered, 1-cycle latency)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, rr_ptr=0, grant_id=0.
//   - Op regs, rsp_s, rsp_valid, add_en all 0.
//   - Asserting reset mid-operation aborts the transaction; no response is ever issued for it.
//  FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//  IDLE:
//   - req_ready = one-hot of the first req_valid bit at or after rr_ptr, searching upward with wrap.
//   - req_ready is combinational from req_valid and rr_ptr; it is 0 in every other state.
//   - On an accept edge:
//     - op_a/op_b <= the granted slices; grant_id <= g.
//     - rr_ptr <= (g+1) mod N_REQ; state <= ISSUE.
//  ISSUE:
//   - add_en=1 for exactly this cycle.
//   - add_a/add_b = op_a/op_b. These outputs always mirror op_a/op_b; op regs change only on accept.
//   - Next state: CAPTURE.
//  CAPTURE:
//   - add_en=0; add_s is now valid.
//   - At the edge: rsp_s <= add_s; rsp_valid <= onehot(grant_id); state <= RESP.
//  RESP:
//   - rsp_valid and rsp_s are held stable until rsp_ready[grant_id]=1 at an edge.
//   - On that edge rsp_valid <= 0 and state <= IDLE.
//   - rsp_ready on non-granted bits is ignored.
//  Timing:
//   - rsp_valid rises 3 clock edges after the accept edge.
//   - Minimum issue interval is 4 cycles per request.
//  Arithmetic:
//   - Sum is modulo 2^WIDTH, with no carry out (e.g. 300+300 -> 88).
//   - The block passes add_s through unmodified.
//  Boundary cases:
//   - No req_valid bits set: stay in IDLE, rr_ptr unchanged.
//   - Requester drops req_valid before being granted: no effect.
//   - Requests arriving during a transaction wait; there is no queueing beyond req_valid.
//   - rr_ptr wraps from N_REQ-1 to 0.
// STRUCTURE
//  - Shared package binary_add_pkg: ADD_WIDTH=9, state typedef {IDLE, ISSUE, CAPTURE, RESP} (2-bit).
//  - Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot grant plus its index.
//    Purely combinational; it is the only natural split.
//  - The adder stays external and is instantiated alongside this block at the top level.
// TESTING  (bench instantiates this block plus the adder; clk period 10)
//  1. Reset: rst_n=0 with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, add_en=0.
//  2. Single request: req0 A=100 B=55 -> add_en pulses 1 cycle.
//     rsp_valid=4'b0001 and rsp_s=155 exactly 3 edges after accept; both hold while rsp_ready=0.
//  3. Round-robin: all 4 requesters valid continuously, each returning rsp_ready promptly.
//     Grant order is 0,1,2,3,0; every sum matches i+j mod 512.
//  4. Wrap/boundary: A=511 B=1 -> rsp_s=0; A=300 B=300 -> rsp_s=88; A=0 B=0 -> rsp_s=0.
//  5. Pointer skip: rr_ptr=2 and only req1 valid -> req1 granted; rr_ptr becomes 2.
//  6. Abort: rst_n pulsed low during CAPTURE.
//     -> rsp_valid stays 0, state=IDLE, next request served normally.

Source files
------------

// File: rtl/binary_add_pkg.sv
// rtl/binary_add_pkg.sv - shared width and FSM state type for the adder arbiter
package binary_add_pkg;

    localparam int ADD_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, with wrap
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/binary_add_arbiter.sv
// rtl/binary_add_arbiter.sv - round-robin sharing of one registered external adder among N_REQ requesters
module binary_add_arbiter
    import binary_add_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_s,
    output logic                   add_en,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH-1:0]       add_s
);

    localparam int IW = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   rsp_s_q, rsp_s_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IW-1:0]      arb_idx;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_s_d     = rsp_s_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;
        add_en      = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are withheld while reset is held so nothing is offered mid-reset.
                if (rst_n) begin
                    req_ready = arb_grant;
                    if (|arb_grant) begin
                        op_a_d     = req_a[arb_idx*WIDTH +: WIDTH];
                        op_b_d     = req_b[arb_idx*WIDTH +: WIDTH];
                        grant_id_d = arb_idx;
                        rr_ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                add_en  = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_s_d     = add_s;
                rsp_valid_d = N_REQ'(1) << grant_id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[grant_id_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_s_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_s_q     <= rsp_s_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_binary_add_arbiter.sv
// tb/tb_binary_add_arbiter.sv - randomized self-checking bench for binary_add_arbiter with a registered adder
module tb_binary_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [35:0] req_a;
    logic [35:0] req_b;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [8:0]  rsp_s;
    logic        add_en;
    logic [8:0]  add_a;
    logic [8:0]  add_b;
    logic [8:0]  add_s;

    int total = 0;
    int bad   = 0;
    int mdl_ptr = 0;
    int op_a[4];
    int op_b[4];

    always #5 clk = ~clk;

    // External registered adder with clock enable.
    always_ff @(posedge clk) begin
        if (add_en) begin
            add_s <= add_a + add_b;
        end
    end

    binary_add_arbiter #(.N_REQ(4), .WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s)
    );

    function automatic int mdl_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] r;
        r = 4'b0000;
        if (g >= 0 && g < 4) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_ops(input int r, input int a, input int b);
        op_a[r] = a;
        op_b[r] = b;
        req_a[r*9 +: 9] = 9'(a);
        req_b[r*9 +: 9] = 9'(b);
    endtask

    // Drives one transaction and reports observations; comparisons are made by the callers.
    task automatic txn(input int hold, output logic [3:0] rdy, output int lat, output int en_cnt,
                       output logic [8:0] s, output logic [3:0] rv_seen, output bit hold_ok,
                       output logic [3:0] rv_after);
        int n;
        rdy = 4'b0; lat = 0; en_cnt = 0; s = '0; rv_seen = 4'b0; hold_ok = 1'b1; rv_after = 4'b0;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rdy = req_ready;
        if (rdy == 4'b0) return;
        @(negedge clk);
        lat = 1;
        while (rsp_valid == 4'b0 && lat < 10) begin
            en_cnt += int'(add_en);
            @(negedge clk);
            lat++;
        end
        rv_seen = rsp_valid;
        s = rsp_s;
        if (rv_seen == 4'b0) return;
        repeat (hold) begin
            rsp_ready = ~rv_seen;
            @(negedge clk);
            if (rsp_valid !== rv_seen || rsp_s !== s) hold_ok = 1'b0;
        end
        rsp_ready = rv_seen;
        @(negedge clk);
        rsp_ready = 4'b0;
        rv_after = rsp_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'b0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready: got %b need 0000", req_ready); end
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b need 0000", rsp_valid); end
        total++; if (add_en !== 1'b0) begin bad++; $display("FAIL reset_add_en: got %b need 0", add_en); end
        total++; if (rsp_s !== 9'd0 || add_a !== 9'd0 || add_b !== 9'd0) begin
            bad++; $display("FAIL reset_regs: rsp_s=%0d add_a=%0d add_b=%0d need 0", rsp_s, add_a, add_b);
        end
        rst_n = 1'b1;
        #1;
        mdl_ptr = 0;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b need 0001", req_ready); end
        req_valid = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] rdy, rv, rva; int lat, en, eg; logic [8:0] s; bit hok;
        for (int r = 0; r < 4; r++) set_ops(r, $urandom_range(0, 511), $urandom_range(0, 511));
        req_valid = 4'hF;
        for (int t = 0; t < 5; t++) begin
            eg = mdl_grant(4'hF, mdl_ptr);
            txn(t % 2, rdy, lat, en, s, rv, hok, rva);
            total++; if (rdy !== onehot(eg)) begin bad++; $display("FAIL rr_grant[%0d]: got %b need %b", t, rdy, onehot(eg)); end
            total++; if (s !== 9'((op_a[eg] + op_b[eg]) % 512)) begin
                bad++; $display("FAIL rr_sum[%0d]: got %0d need %0d", t, s, (op_a[eg] + op_b[eg]) % 512);
            end
            total++; if (rv !== onehot(eg) || lat != 3) begin
                bad++; $display("FAIL rr_rsp[%0d]: rsp_valid=%b lat=%0d need %b lat=3", t, rv, lat, onehot(eg));
            end
            mdl_ptr = (eg + 1) % 4;
            set_ops(eg, $urandom_range(0, 511), $urandom_range(0, 511));
        end
        req_valid = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] rdy, rv, rva; int lat, en; logic [8:0] s; bit hok;
        set_ops(0, 100, 55);
        req_valid = 4'b0001;
        txn(3, rdy, lat, en, s, rv, hok, rva);
        req_valid = 4'b0;
        mdl_ptr = 1;
        total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b need 0001", rdy); end
        total++; if (en != 1) begin bad++; $display("FAIL single_add_en_pulse: got %0d cycles need 1", en); end
        total++; if (lat != 3) begin bad++; $display("FAIL single_latency: got %0d edges need 3", lat); end
        total++; if (rv !== 4'b0001 || s !== 9'd155) begin
            bad++; $display("FAIL single_rsp: rsp_valid=%b rsp_s=%0d need 0001 155", rv, s);
        end
        total++; if (!hok) begin bad++; $display("FAIL single_hold: rsp changed while waiting, need stable"); end
        total++; if (rva !== 4'b0) begin bad++; $display("FAIL single_release: rsp_valid=%b need 0000", rva); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int ta[3] = '{511, 300, 0};
        int tb[3] = '{1, 300, 0};
        int te[3] = '{0, 88, 0};
        logic [3:0] rdy, rv, rva; int lat, en; logic [8:0] s; bit hok;
        for (int k = 0; k < 3; k++) begin
            set_ops(k + 1, ta[k], tb[k]);
            req_valid = onehot(k + 1);
            txn(0, rdy, lat, en, s, rv, hok, rva);
            req_valid = 4'b0;
            mdl_ptr = (k + 2) % 4;
            total++; if (rdy !== onehot(k + 1) || s !== 9'(te[k])) begin
                bad++; $display("FAIL wrap_sum[%0d]: grant=%b sum=%0d need %b %0d", k, rdy, s, onehot(k + 1), te[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ptr_skip();
        logic [3:0] rdy, rv, rva; int lat, en, eg; logic [8:0] s; bit hok;
        logic [3:0] masks[3] = '{4'b0010, 4'b0010, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 4; r++) set_ops(r, $urandom_range(0, 511), $urandom_range(0, 511));
            req_valid = masks[k];
            eg = mdl_grant(masks[k], mdl_ptr);
            txn(0, rdy, lat, en, s, rv, hok, rva);
            req_valid = 4'b0;
            mdl_ptr = (eg + 1) % 4;
            total++; if (rdy !== onehot(eg) || s !== 9'((op_a[eg] + op_b[eg]) % 512)) begin
                bad++; $display("FAIL ptr_skip[%0d]: grant=%b sum=%0d need %b %0d", k, rdy, s, onehot(eg), (op_a[eg] + op_b[eg]) % 512);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [3:0] rdy, rv, rva; int lat, en, n; logic [8:0] s; bit hok, quiet;
        set_ops(3, 200, 17);
        req_valid = 4'b1000;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 4'b0;
        @(negedge clk);
        total++; if (add_en !== 1'b0 || rsp_valid !== 4'b0) begin
            bad++; $display("FAIL abort_in_capture: add_en=%b rsp_valid=%b need 0 0000", add_en, rsp_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_ptr = 0;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0 || add_en !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL abort_no_rsp: response or adder activity seen after abort, need none"); end
        for (int r = 0; r < 4; r++) set_ops(r, $urandom_range(0, 511), $urandom_range(0, 511));
        req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL abort_idle_ptr: req_ready=%b need 0001", req_ready); end
        txn(1, rdy, lat, en, s, rv, hok, rva);
        req_valid = 4'b0;
        mdl_ptr = 1;
        total++; if (rv !== 4'b0001 || lat != 3 || s !== 9'((op_a[0] + op_b[0]) % 512)) begin
            bad++; $display("FAIL abort_next_txn: rsp_valid=%b lat=%0d sum=%0d need 0001 3 %0d", rv, lat, s, (op_a[0] + op_b[0]) % 512);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] rdy, rv, rva, m; int lat, en, eg; logic [8:0] s; bit hok;
        req_valid = 4'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (req_ready !== 4'b0 || add_en !== 1'b0) begin
                bad++; $display("FAIL idle_no_req: req_ready=%b add_en=%b need 0000 0", req_ready, add_en);
            end
        end
        for (int t = 0; t < 40; t++) begin
            m = 4'($urandom_range(1, 15));
            for (int r = 0; r < 4; r++) set_ops(r, $urandom_range(0, 511), $urandom_range(0, 511));
            req_valid = m;
            eg = mdl_grant(m, mdl_ptr);
            txn($urandom_range(0, 2), rdy, lat, en, s, rv, hok, rva);
            req_valid = 4'b0;
            mdl_ptr = (eg + 1) % 4;
            total++; if (rdy !== onehot(eg) || rv !== onehot(eg)) begin
                bad++; $display("FAIL rand_grant[%0d]: grant=%b rsp_valid=%b need %b", t, rdy, rv, onehot(eg));
            end
            total++; if (s !== 9'((op_a[eg] + op_b[eg]) % 512) || lat != 3 || en != 1 || !hok || rva !== 4'b0) begin
                bad++; $display("FAIL rand_rsp[%0d]: sum=%0d lat=%0d en=%0d hold=%0d after=%b need %0d 3 1 1 0000",
                                t, s, lat, en, hok, rva, (op_a[eg] + op_b[eg]) % 512);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, need finish before 500000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_ptr_skip();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
